iir_inv_pipe: RTL and testbench

IIR_INV_PIPE -- requirements
Module: iir_inv_pipe

---
 rtl/iir_inv_pipe_if.sv | 41 ++++
 rtl/iir_inv_pipe.sv | 121 ++++++++++++
 tb/tb_iir_inv_pipe.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/iir_inv_pipe_if.sv
// rtl/iir_inv_pipe_if.sv - sample stream handshake bundle for the inverse IIR equalizer
//
// Purpose: groups the input sample stream (y_in/in_valid/in_ready) and the
// output sample stream (x_out/out_valid/out_ready) of iir_inv_pipe.
// Ports (signals):
//   y_in      W+1 signed  sample offered to the equalizer
//   in_valid  1           y_in carries a sample
//   in_ready  1           equalizer accepts a sample this cycle
//   x_out     W+1 signed  recovered sample
//   out_valid 1           x_out holds a sample
//   out_ready 1           downstream accepts x_out this cycle
// Modports: master = sample source / sink side, slave = equalizer side.

interface iir_inv_pipe_if #(
   parameter int W = 14
);
   logic signed [W:0] y_in;
   logic              in_valid;
   logic              in_ready;
   logic signed [W:0] x_out;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output y_in,
      output in_valid,
      input  in_ready,
      input  x_out,
      input  out_valid,
      output out_ready
   );

   modport slave (
      input  y_in,
      input  in_valid,
      output in_ready,
      output x_out,
      output out_valid,
      input  out_ready
   );
endinterface

// File: rtl/iir_inv_pipe.sv
// rtl/iir_inv_pipe.sv - 3-stage pipelined inverse of y[n] = x[n] + 3/4*y[n-1]
//
// Purpose: recovers x[n] = y[n] - ((y[n-1]>>>1) + (y[n-1]>>>2)) with
// saturation to W+1 bits, a sticky saturation flag and an output counter.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   clr         synchronous clear of history, valids, sat and counter
//   bus         sample streams (iir_inv_pipe_if.slave)
//   sat         sticky: some output was clipped
//   sample_cnt  number of output samples transferred (wraps)

module iir_inv_pipe #(
   parameter int W = 14
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   iir_inv_pipe_if.slave bus,
   output logic          sat,
   output logic [15:0]   sample_cnt
);

   // Single global enable: the whole pipe freezes while the output is held.
   logic en;
   logic accept;

   logic signed [W:0]   hist;
   logic                s1_v;
   logic signed [W:0]   s1_y;
   logic signed [W:0]   s1_yp;
   logic                s2_v;
   logic signed [W:0]   s2_y;
   logic signed [W:0]   s2_d;
   logic                s3_v;
   logic signed [W:0]   s3_x;

   logic signed [W:0]   d_next;
   logic signed [W+1:0] diff;
   logic signed [W:0]   sat_val;
   logic                clip;

   assign en           = !s3_v || bus.out_ready;
   assign accept       = bus.in_valid && en;
   assign bus.in_ready = en;
   assign bus.x_out    = s3_x;
   assign bus.out_valid = s3_v;

   // 3/4 of the previous sample; each term is at most half / quarter of the
   // range, so the sum always fits in W+1 bits.
   assign d_next = (s1_yp >>> 1) + (s1_yp >>> 2);

   // One extra bit holds the full difference range before clipping.
   assign diff = {s2_y[W], s2_y} - {s2_d[W], s2_d};

   // Overflow shows as disagreement between the two top bits of diff.
   always_comb begin
      clip    = 1'b0;
      sat_val = diff[W:0];
      if (diff[W+1] != diff[W]) begin
         clip = 1'b1;
         if (diff[W+1]) begin
            sat_val = {1'b1, {W{1'b0}}};
         end else begin
            sat_val = {1'b0, {W{1'b1}}};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist       <= '0;
         s1_v       <= 1'b0;
         s1_y       <= '0;
         s1_yp      <= '0;
         s2_v       <= 1'b0;
         s2_y       <= '0;
         s2_d       <= '0;
         s3_v       <= 1'b0;
         s3_x       <= '0;
         sat        <= 1'b0;
         sample_cnt <= '0;
      end else if (clr) begin
         // Clear wins over the enable and drops any sample offered now.
         hist       <= '0;
         s1_v       <= 1'b0;
         s2_v       <= 1'b0;
         s3_v       <= 1'b0;
         sat        <= 1'b0;
         sample_cnt <= '0;
      end else begin
         if (s3_v && bus.out_ready) begin
            sample_cnt <= sample_cnt + 16'd1;
         end
         if (en) begin
            // Stage 1: capture the new sample with the history it pairs with.
            s1_v <= accept;
            if (accept) begin
               s1_y  <= bus.y_in;
               s1_yp <= hist;
               hist  <= bus.y_in;
            end
            // Stage 2: sample and feedback term.
            s2_v <= s1_v;
            if (s1_v) begin
               s2_y <= s1_y;
               s2_d <= d_next;
            end
            // Stage 3: saturated result; bubbles leave the last value in place.
            s3_v <= s2_v;
            if (s2_v) begin
               s3_x <= sat_val;
               if (clip) begin
                  sat <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_iir_inv_pipe.sv
// tb/tb_iir_inv_pipe.sv - directed self-checking bench for iir_inv_pipe

module tb_iir_inv_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr;
   logic        sat;
   logic [15:0] sample_cnt;

   iir_inv_pipe_if #(.W(14)) ifc ();

   iir_inv_pipe #(.W(14)) dut (
      .clk        (clk),
      .reset      (reset),
      .clr        (clr),
      .bus        (ifc),
      .sat        (sat),
      .sample_cnt (sample_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int got[$];

   // Outputs transfer on the next rising edge; inputs only move just after one.
   always @(negedge clk) begin
      if (!reset && ifc.out_valid && ifc.out_ready) begin
         got.push_back(int'($signed(ifc.x_out)));
      end
   end

   task automatic check(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic push(input int v);
      int t = 0;
      ifc.y_in     = 15'(v);
      ifc.in_valid = 1'b1;
      @(negedge clk);
      while (!ifc.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check("push_timeout", t, 0);
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int t = 0;
      while (got.size() < n && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (got.size() < n) check("out_timeout", got.size(), n);
   endtask

   task automatic do_clr();
      ifc.in_valid = 1'b0;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      got.delete();
   endtask

   task automatic run_seq(input string tag, input int n, input int vin[16], input int vexp[16]);
      do_clr();
      for (int i = 0; i < n; i++) push(vin[i]);
      wait_out(n);
      for (int i = 0; i < n; i++) begin
         if (i < got.size()) check($sformatf("%s[%0d]", tag, i), got[i], vexp[i]);
      end
      check({tag, "_count"}, got.size(), n);
   endtask

   int vin[16];
   int vexp[16];
   int hold;

   initial begin
      reset         = 1'b1;
      clr           = 1'b0;
      ifc.y_in      = '0;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      #1;
      check("rst_out_valid", int'(ifc.out_valid), 0);
      check("rst_x_out", int'($signed(ifc.x_out)), 0);
      check("rst_sat", int'(sat), 0);
      check("rst_cnt", int'(sample_cnt), 0);
      check("rst_in_ready", int'(ifc.in_ready), 1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Latency: output valid on the third edge counting the accepting one.
      do_clr();
      push(1000);
      check("lat_e1", int'(ifc.out_valid), 0);
      @(posedge clk); #1;
      check("lat_e2", int'(ifc.out_valid), 0);
      @(posedge clk); #1;
      check("lat_e3", int'(ifc.out_valid), 1);
      check("lat_x", int'($signed(ifc.x_out)), 1000);
      wait_out(1);

      // Impulse
      vin[0] = 1000; vin[1] = 0; vin[2] = 0;
      vexp[0] = 1000; vexp[1] = -750; vexp[2] = 0;
      run_seq("impulse", 3, vin, vexp);
      check("impulse_sat", int'(sat), 0);

      // Step
      for (int i = 0; i < 6; i++) begin
         vin[i]  = 1000;
         vexp[i] = (i == 0) ? 1000 : 250;
      end
      run_seq("step", 6, vin, vexp);
      @(posedge clk); #1;
      check("step_cnt", int'(sample_cnt), 6);

      // Truncation toward minus infinity: d(-1) = -2
      vin[0] = -1; vin[1] = 0;
      vexp[0] = -1; vexp[1] = 2;
      run_seq("trunc", 2, vin, vexp);

      // Saturation, then a clean sample with the flag still held
      vin[0] = 16383; vin[1] = -16384; vin[2] = 0;
      vexp[0] = 16383; vexp[1] = -16384; vexp[2] = 12288;
      run_seq("satur", 3, vin, vexp);
      repeat (3) @(posedge clk);
      #1;
      check("sat_sticky", int'(sat), 1);
      do_clr();
      check("sat_clr", int'(sat), 0);
      check("cnt_clr", int'(sample_cnt), 0);

      // Backpressure: stream 1..10 with a stall in the middle
      do_clr();
      fork
         begin
            for (int i = 1; i <= 10; i++) push(i);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            ifc.out_ready = 1'b0;
            @(negedge clk);
            check("bp_valid", int'(ifc.out_valid), 1);
            hold = int'($signed(ifc.x_out));
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               check($sformatf("bp_in_ready%0d", k), int'(ifc.in_ready), 0);
               check($sformatf("bp_hold%0d", k), int'($signed(ifc.x_out)), hold);
               check($sformatf("bp_vhold%0d", k), int'(ifc.out_valid), 1);
            end
            @(posedge clk);
            #1;
            ifc.out_ready = 1'b1;
         end
      join
      wait_out(10);
      vexp[0] = 1; vexp[1] = 2; vexp[2] = 2; vexp[3] = 3; vexp[4] = 2;
      vexp[5] = 3; vexp[6] = 3; vexp[7] = 4; vexp[8] = 3; vexp[9] = 4;
      for (int i = 0; i < 10; i++) begin
         if (i < got.size()) check($sformatf("bp[%0d]", i), got[i], vexp[i]);
      end
      repeat (4) @(posedge clk);
      #1;
      check("bp_count", got.size(), 10);
      check("bp_cnt", int'(sample_cnt), 10);

      // Reset with three samples in flight
      do_clr();
      push(10);
      push(20);
      push(30);
      reset = 1'b1;
      #1;
      check("mrst_valid", int'(ifc.out_valid), 0);
      check("mrst_x", int'($signed(ifc.x_out)), 0);
      check("mrst_cnt", int'(sample_cnt), 0);
      check("mrst_in_ready", int'(ifc.in_ready), 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      got.delete();
      repeat (6) @(posedge clk);
      #1;
      check("mrst_stale", got.size(), 0);
      push(500);
      wait_out(1);
      if (got.size() > 0) check("mrst_first", got[0], 500);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
